spi_frame_deserializer: RTL and testbench

Clocked, parametrised replacement for the unclocked SPI deserializer on the sensor tap. Passively snoops the sensor SPI bus (SCK, CS_n, MISO) shared with the RP2350, synchronises it into the FPGA system clock, strips the command phase, and splits each CS frame into N_CH words of DATA_W bits. Words are buffered in a small FIFO and presented to the Kalman filter over a valid/ready stream with channel index and last-of-frame flag.

---
 rtl/spi_frame_pkg.sv | 19 +
 rtl/spi_frame_deserializer_sync_2ff.sv | 31 +++
 rtl/spi_frame_deserializer.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_frame_deserializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared types and helpers for the SPI frame deserializer.
//   state_t        - frame-parsing FSM states
//   sample_on_rise - selects which SCK edge carries valid MISO data
package spi_frame_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    SKIP      = 3'd2,
    DATA      = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_frame_deserializer_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous single-bit inputs.
//   clk, rst_n - system clock, async active-low reset
//   d          - asynchronous input bits
//   q          - synchronised output bits (reset to RST_VAL)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability chain: first stage may resolve slowly, second is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_frame_deserializer.sv
// spi_frame_deserializer: passive SPI snooper that splits each CS frame into
// N_CH words of DATA_W bits and streams them out through a small FWFT FIFO.
//   clk, rst_n                  - system clock (>= 4x SCK), async active-low reset
//   spi_sck, spi_cs_n, spi_miso - snooped bus, asynchronous to clk
//   m_data, m_ch, m_last        - FIFO head: word, channel index, last-of-frame
//   m_valid, m_ready            - output stream handshake
//   overflow                    - 1-cycle pulse: word dropped, FIFO full
//   frame_err                   - 1-cycle pulse: CS_n rose before frame complete
module spi_frame_deserializer
  import spi_frame_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int N_CH       = 3,
  parameter int SKIP_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_miso,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overflow,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(((DATA_W > SKIP_BITS) ? DATA_W : SKIP_BITS) + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic RISE = sample_on_rise(1'(CPOL), 1'(CPHA));
  localparam logic [CNT_W-1:0] SKIP_LAST = (SKIP_BITS > 0) ? CNT_W'(SKIP_BITS - 1) : '0;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  // CS_n synchroniser resets to "selected" so a frame already running at
  // reset release keeps the FSM in WAIT_IDLE until the bus goes idle.
  logic [2:0] sync_s;
  logic       sck_s, cs_s, miso_s;

  sync_2ff #(.WIDTH(3), .RST_VAL(3'b000)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({spi_sck, spi_cs_n, spi_miso}),
    .q     (sync_s)
  );
  assign {sck_s, cs_s, miso_s} = sync_s;

  state_t                  state_q, state_d;
  logic                    sck_prev_q, cs_prev_q;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic [DATA_W-1:0]       word_q, word_d;
  logic                    push_q, push_d;
  logic [DATA_W-1:0]       push_word_q, push_word_d;
  logic [CH_W-1:0]         push_ch_q, push_ch_d;
  logic                    push_last_q, push_last_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overflow_q, overflow_d;
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]       mem_data_q [FIFO_DEPTH];
  logic [CH_W-1:0]         mem_ch_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   mem_last_q;

  logic              sample_s, frame_done_s, empty_s, full_s, pop_s, wr_en_s;
  logic [DATA_W-1:0] shifted_s;

  // Edge detect and next-state logic for the frame parser.
  always_comb begin
    // Gating with the registered CS_n (one cycle older than cs_s) lets an edge
    // that arrives together with CS_n rising still count as a sample.
    sample_s     = (RISE ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q)) & ~cs_prev_q;
    shifted_s    = (MSB_FIRST != 0) ? {word_q[DATA_W-2:0], miso_s}
                                    : {miso_s, word_q[DATA_W-1:1]};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    word_d       = word_q;
    push_d       = 1'b0;
    push_word_d  = push_word_q;
    push_ch_d    = push_ch_q;
    push_last_d  = push_last_q;
    frame_err_d  = 1'b0;
    frame_done_s = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (cs_s) state_d = IDLE;
        else      state_d = WAIT_IDLE;
      end
      IDLE: begin
        bit_cnt_d = '0;
        ch_cnt_d  = '0;
        if (!cs_s) state_d = (SKIP_BITS == 0) ? DATA : SKIP;
        else       state_d = IDLE;
      end
      SKIP: begin
        if (sample_s) begin
          if (bit_cnt_q == SKIP_LAST) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        if (cs_s) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          frame_err_d = 1'b0;
        end
      end
      DATA: begin
        if (sample_s) begin
          word_d = shifted_s;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d   = '0;
            push_d      = 1'b1;
            push_word_d = shifted_s;
            push_ch_d   = ch_cnt_q;
            push_last_d = (ch_cnt_q == CH_LAST);
            if (ch_cnt_q == CH_LAST) begin
              frame_done_s = 1'b1;
              state_d      = DONE;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          word_d = word_q;
        end
        // The sample above is handled first, so a frame that completes in the
        // same cycle CS_n rises is a clean end of frame.
        if (cs_s && !frame_done_s) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          frame_err_d = 1'b0;
        end
      end
      DONE: begin
        if (cs_s) state_d = IDLE;
        else      state_d = DONE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // FIFO pointer and overflow logic; a pop frees the slot a full push needs.
  always_comb begin
    empty_s    = (wr_ptr_q == rd_ptr_q);
    full_s     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop_s      = !empty_s && m_ready;
    wr_en_s    = push_q && (!full_s || pop_s);
    overflow_d = push_q && full_s && !pop_s;
    if (wr_en_s) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    else         wr_ptr_d = wr_ptr_q;
    if (pop_s)   rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    else         rd_ptr_d = rd_ptr_q;
  end

  // State, counters, push staging, FIFO storage and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_IDLE;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      push_ch_q   <= '0;
      push_last_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_last_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_ch_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      word_q      <= word_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      push_ch_q   <= push_ch_d;
      push_last_q <= push_last_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (wr_en_s) begin
        mem_data_q[wr_ptr_q[PTR_W-1:0]] <= push_word_q;
        mem_ch_q[wr_ptr_q[PTR_W-1:0]]   <= push_ch_q;
        mem_last_q[wr_ptr_q[PTR_W-1:0]] <= push_last_q;
      end
    end
  end

  assign m_valid   = !empty_s;
  assign m_data    = mem_data_q[rd_ptr_q[PTR_W-1:0]];
  assign m_ch      = mem_ch_q[rd_ptr_q[PTR_W-1:0]];
  assign m_last    = mem_last_q[rd_ptr_q[PTR_W-1:0]];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_frame_deserializer.sv
// Directed bench: dut0 uses default parameters (mode 0, MSB first, 3 channels,
// 8 skip bits); dut1 uses mode 3, LSB first, 2 channels, no skip bits.
module tb_spi_frame_deserializer;

  logic clk = 1'b0;
  logic rst_n, sck0, sck1, cs0_n, cs1_n, miso, m_ready0;
  logic m_ready1 = 1'b1;

  logic [15:0] d0_data, d1_data;
  logic [1:0]  d0_ch;
  logic [0:0]  d1_ch;
  logic d0_last, d0_valid, d0_ovf, d0_ferr;
  logic d1_last, d1_valid, d1_ovf, d1_ferr;

  int n_checks = 0;
  int n_errors = 0;
  int ovf0 = 0, ferr0 = 0, ovf1 = 0, ferr1 = 0;
  logic [18:0] q0[$];
  logic [17:0] q1[$];

  always #5 clk = ~clk;

  spi_frame_deserializer dut0 (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck0), .spi_cs_n(cs0_n), .spi_miso(miso),
    .m_data(d0_data), .m_ch(d0_ch), .m_last(d0_last), .m_valid(d0_valid),
    .m_ready(m_ready0), .overflow(d0_ovf), .frame_err(d0_ferr)
  );

  spi_frame_deserializer #(
    .DATA_W(16), .N_CH(2), .SKIP_BITS(0), .FIFO_DEPTH(4),
    .MSB_FIRST(0), .CPOL(1), .CPHA(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck1), .spi_cs_n(cs1_n), .spi_miso(miso),
    .m_data(d1_data), .m_ch(d1_ch), .m_last(d1_last), .m_valid(d1_valid),
    .m_ready(m_ready1), .overflow(d1_ovf), .frame_err(d1_ferr)
  );

  // Record every accepted beat and every pulse cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (d0_valid && m_ready0) q0.push_back({d0_last, d0_ch, d0_data});
    if (d1_valid && m_ready1) q1.push_back({d1_last, d1_ch, d1_data});
    if (d0_ovf)  ovf0++;
    if (d0_ferr) ferr0++;
    if (d1_ovf)  ovf1++;
    if (d1_ferr) ferr1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp0(input string tag, input int idx, input logic [15:0] d,
                      input logic [1:0] ch, input logic l);
    logic [18:0] e;
    e = (idx < q0.size()) ? q0[idx] : 19'h7FFFF;
    check({tag, "_data"}, {16'h0, e[15:0]}, {16'h0, d});
    check({tag, "_ch"},   {30'h0, e[17:16]}, {30'h0, ch});
    check({tag, "_last"}, {31'h0, e[18]},    {31'h0, l});
  endtask

  task automatic exp1(input string tag, input int idx, input logic [15:0] d,
                      input logic ch, input logic l);
    logic [17:0] e;
    e = (idx < q1.size()) ? q1[idx] : 18'h3FFFF;
    check({tag, "_data"}, {16'h0, e[15:0]}, {16'h0, d});
    check({tag, "_ch"},   {31'h0, e[16]},   {31'h0, ch});
    check({tag, "_last"}, {31'h0, e[17]},   {31'h0, l});
  endtask

  // One bit per 80 ns (8 clk): data set, leading edge, trailing edge.
  // pop_last raises m_ready0 for exactly the clk edge on which the final
  // bit's word is written into the FIFO.
  task automatic send_bits(input logic [31:0] v, input int n, input bit lsb_first,
                           input bit pop_last);
    for (int i = 0; i < n; i++) begin
      miso = lsb_first ? v[i] : v[n-1-i];
      #20 sck0 = 1'b1; sck1 = 1'b0;
      if (pop_last && i == n - 1) begin
        #26 m_ready0 = 1'b1;
        #10 m_ready0 = 1'b0;
        #4;
      end else begin
        #40;
      end
      sck0 = 1'b0; sck1 = 1'b1;
      #20;
    end
  endtask

  task automatic frame0(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    cs0_n = 1'b0; #40;
    send_bits(32'hC3, 8, 1'b0, 1'b0);
    send_bits({16'h0, a}, 16, 1'b0, 1'b0);
    send_bits({16'h0, b}, 16, 1'b0, 1'b0);
    send_bits({16'h0, c}, 16, 1'b0, 1'b0);
    #40 cs0_n = 1'b1; #200;
  endtask

  int f0, o0;

  initial begin
    rst_n = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1; sck0 = 1'b0; sck1 = 1'b1;
    miso = 1'b0; m_ready0 = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", {31'h0, d0_valid}, 32'h0);
    check("rst_data",  {16'h0, d0_data},  32'h0);
    check("rst_ch",    {30'h0, d0_ch},    32'h0);
    check("rst_last",  {31'h0, d0_last},  32'h0);
    check("rst_ovf",   {31'h0, d0_ovf},   32'h0);
    check("rst_ferr",  {31'h0, d0_ferr},  32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic mode-0 frame.
    frame0(16'h1234, 16'hABCD, 16'h0F0F);
    check("t1_count", q0.size(), 32'd3);
    exp0("t1_w0", 0, 16'h1234, 2'd0, 1'b0);
    exp0("t1_w1", 1, 16'hABCD, 2'd1, 1'b0);
    exp0("t1_w2", 2, 16'h0F0F, 2'd2, 1'b1);
    check("t1_ovf",  ovf0,  32'd0);
    check("t1_ferr", ferr0, 32'd0);
    q0.delete();

    // Mode 3, LSB first, no skip phase, two channels.
    cs1_n = 1'b0; #40;
    send_bits(32'h8001, 16, 1'b1, 1'b0);
    send_bits(32'h00FF, 16, 1'b1, 1'b0);
    #40 cs1_n = 1'b1; #200;
    check("t2_count", q1.size(), 32'd2);
    exp1("t2_w0", 0, 16'h8001, 1'b0, 1'b0);
    exp1("t2_w1", 1, 16'h00FF, 1'b1, 1'b1);
    check("t2_ferr", ferr1, 32'd0);
    check("t2_ovf",  ovf1,  32'd0);

    // Frame aborted five bits into the second word.
    cs0_n = 1'b0; #40;
    send_bits(32'hC3, 8, 1'b0, 1'b0);
    send_bits(32'h1234, 16, 1'b0, 1'b0);
    send_bits(32'h1F, 5, 1'b0, 1'b0);
    #40 cs0_n = 1'b1; #200;
    check("t3_count", q0.size(), 32'd1);
    exp0("t3_w0", 0, 16'h1234, 2'd0, 1'b0);
    check("t3_ferr", ferr0, 32'd1);
    q0.delete();
    frame0(16'h1111, 16'h2222, 16'h3333);
    check("t3b_count", q0.size(), 32'd3);
    exp0("t3b_w0", 0, 16'h1111, 2'd0, 1'b0);
    exp0("t3b_w2", 2, 16'h3333, 2'd2, 1'b1);
    check("t3b_ferr", ferr0, 32'd1);
    q0.delete();

    // Reset mid-DATA, released while CS_n stays low: rest of frame ignored.
    f0 = ferr0;
    cs0_n = 1'b0; #40;
    send_bits(32'hC3, 8, 1'b0, 1'b0);
    send_bits(32'h15, 6, 1'b0, 1'b0);
    rst_n = 1'b0; #30 rst_n = 1'b1;
    send_bits(32'h155, 10, 1'b0, 1'b0);
    send_bits(32'h6666, 16, 1'b0, 1'b0);
    send_bits(32'h7777, 16, 1'b0, 1'b0);
    #40 cs0_n = 1'b1; #200;
    check("t5_count", q0.size(), 32'd0);
    check("t5_ferr", ferr0 - f0, 32'd0);
    frame0(16'hAAAA, 16'hBBBB, 16'hCCCC);
    check("t5b_count", q0.size(), 32'd3);
    exp0("t5b_w0", 0, 16'hAAAA, 2'd0, 1'b0);
    exp0("t5b_w1", 1, 16'hBBBB, 2'd1, 1'b0);
    exp0("t5b_w2", 2, 16'hCCCC, 2'd2, 1'b1);
    q0.delete();

    // Stalled sink: two frames into a 4-entry FIFO.
    o0 = ovf0;
    @(posedge clk); #1 m_ready0 = 1'b0;
    @(negedge clk);
    frame0(16'h0101, 16'h0202, 16'h0303);
    frame0(16'h0404, 16'h0505, 16'h0606);
    check("t4_ovf", ovf0 - o0, 32'd2);
    check("t4_hold_valid", {31'h0, d0_valid}, 32'h1);
    check("t4_hold_data",  {16'h0, d0_data},  32'h0101);
    @(posedge clk); #1 m_ready0 = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_count", q0.size(), 32'd4);
    exp0("t4_w0", 0, 16'h0101, 2'd0, 1'b0);
    exp0("t4_w1", 1, 16'h0202, 2'd1, 1'b0);
    exp0("t4_w2", 2, 16'h0303, 2'd2, 1'b1);
    exp0("t4_w3", 3, 16'h0404, 2'd0, 1'b0);
    q0.delete();

    // Push with simultaneous pop while full (on 0x1005), then a plain overflow (0x1006).
    o0 = ovf0;
    @(posedge clk); #1 m_ready0 = 1'b0;
    @(negedge clk);
    frame0(16'h1001, 16'h1002, 16'h1003);
    cs0_n = 1'b0; #40;
    send_bits(32'hC3, 8, 1'b0, 1'b0);
    send_bits(32'h1004, 16, 1'b0, 1'b0);
    send_bits(32'h1005, 16, 1'b0, 1'b1);
    send_bits(32'h1006, 16, 1'b0, 1'b0);
    #40 cs0_n = 1'b1; #200;
    check("t6_ovf", ovf0 - o0, 32'd1);
    check("t6_full_valid", {31'h0, d0_valid}, 32'h1);
    check("t6_head", {16'h0, d0_data}, 32'h1002);
    @(posedge clk); #1 m_ready0 = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_count", q0.size(), 32'd5);
    exp0("t6_w0", 0, 16'h1001, 2'd0, 1'b0);
    exp0("t6_w1", 1, 16'h1002, 2'd1, 1'b0);
    exp0("t6_w3", 3, 16'h1004, 2'd0, 1'b0);
    exp0("t6_w4", 4, 16'h1005, 2'd1, 1'b0);
    check("t6_empty", {31'h0, d0_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
